// File: rtl/truth_table_scanner.sv
// Exhaustive stimulus/capture sequencer for a small combinational function:
// steps vec through every input combination, samples f_in into tt and grades it.
module truth_table_scanner #(
  parameter int N_IN   = 3,
  parameter int SETTLE = 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic [(2**N_IN)-1:0]   expected_tt,
  input  logic                   f_in,
  output logic [N_IN-1:0]        vec,
  output logic                   busy,
  output logic                   done,
  output logic [(2**N_IN)-1:0]   tt,
  output logic                   pass,
  output logic                   fail,
  output logic [N_IN-1:0]        first_bad,
  output logic [N_IN:0]          ones
);

  localparam int TW = 2**N_IN;
  localparam int OW = N_IN + 1;
  localparam logic [3:0] SETTLE_CNT = 4'(SETTLE);

  typedef enum logic [1:0] {S_IDLE, S_DRIVE, S_DONE} state_t;

  state_t          r_state;
  logic [3:0]      r_cnt;
  logic [TW-1:0]   r_exp;
  logic [TW-1:0]   r_tt;
  logic [N_IN-1:0] r_vec;
  logic            r_busy;
  logic            r_done;
  logic            r_pass;
  logic            r_fail;
  logic [N_IN-1:0] r_first_bad;
  logic [OW-1:0]   r_ones;

  logic [TW-1:0]   w_tt_samp;
  logic [TW-1:0]   w_diff;
  logic [N_IN-1:0] w_first_bad;
  logic [OW-1:0]   w_ones;
  logic            w_last;

  // Grading works on the table including the bit being sampled this edge,
  // so results are ready in the first cycle done reads 1.
  always_comb begin
    w_tt_samp        = r_tt;
    w_tt_samp[r_vec] = f_in;
    w_diff           = w_tt_samp ^ r_exp;
    w_first_bad      = '0;
    for (int i = TW - 1; i >= 0; i--) begin
      if (w_diff[i]) w_first_bad = N_IN'(i);
    end
    w_ones = '0;
    for (int i = 0; i < TW; i++) begin
      w_ones = w_ones + OW'(w_tt_samp[i]);
    end
    w_last = (r_vec == N_IN'(TW - 1));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_exp       <= '0;
      r_tt        <= '0;
      r_vec       <= '0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_pass      <= 1'b0;
      r_fail      <= 1'b0;
      r_first_bad <= '0;
      r_ones      <= '0;
    end else begin
      case (r_state)
        S_IDLE, S_DONE: begin
          if (start) begin
            r_exp   <= expected_tt;
            r_tt    <= '0;
            r_vec   <= '0;
            r_cnt   <= SETTLE_CNT;
            r_busy  <= 1'b1;
            r_done  <= 1'b0;
            r_pass  <= 1'b0;
            r_fail  <= 1'b0;
            r_state <= S_DRIVE;
          end
        end
        S_DRIVE: begin
          if (r_cnt != 4'd0) begin
            r_cnt <= r_cnt - 4'd1;
          end else begin
            r_tt <= w_tt_samp;
            if (w_last) begin
              r_state     <= S_DONE;
              r_busy      <= 1'b0;
              r_done      <= 1'b1;
              r_pass      <= (w_diff == '0);
              r_fail      <= (w_diff != '0);
              r_first_bad <= w_first_bad;
              r_ones      <= w_ones;
            end else begin
              r_vec <= r_vec + 1'b1;
              r_cnt <= SETTLE_CNT;
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign vec       = r_vec;
  assign busy      = r_busy;
  assign done      = r_done;
  assign tt        = r_tt;
  assign pass      = r_pass;
  assign fail      = r_fail;
  assign first_bad = r_first_bad;
  assign ones      = r_ones;

endmodule

// File: tb/tb_truth_table_scanner.sv
// Bench for truth_table_scanner: directed scans with literal results, then
// random start/reset/table traffic graded every cycle by an elapsed-edge model.
module tb_truth_table_scanner;

  localparam int S = 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic [7:0] expected_tt = 8'h00;
  logic [7:0] fut = 8'h00;
  logic       f_in;
  logic [2:0] vec;
  logic       busy, done, pass, fail;
  logic [7:0] tt;
  logic [2:0] first_bad;
  logic [3:0] ones;

  logic       start0 = 1'b0;
  logic       f0 = 1'b1;
  logic [7:0] exp0 = 8'hFF;
  logic [2:0] vec0;
  logic       busy0, done0, pass0, fail0;
  logic [7:0] tt0;
  logic [2:0] first_bad0;
  logic [3:0] ones0;

  assign f_in = fut[vec];

  truth_table_scanner #(.N_IN(3), .SETTLE(S)) dut (
    .clk(clk), .rst(rst), .start(start), .expected_tt(expected_tt), .f_in(f_in),
    .vec(vec), .busy(busy), .done(done), .tt(tt), .pass(pass), .fail(fail),
    .first_bad(first_bad), .ones(ones)
  );

  truth_table_scanner #(.N_IN(3), .SETTLE(0)) dut0 (
    .clk(clk), .rst(rst), .start(start0), .expected_tt(exp0), .f_in(f0),
    .vec(vec0), .busy(busy0), .done(done0), .tt(tt0), .pass(pass0), .fail(fail0),
    .first_bad(first_bad0), .ones(ones0)
  );

  int total = 0;
  int bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: a scan is just a count of edges since acceptance; vector k is
  // sampled when that count reaches (k+1)*(S+1), and the last one ends the scan.
  logic       m_busy = 1'b0;
  logic       m_done = 1'b0;
  logic [7:0] m_tt = 8'h00;
  logic [7:0] m_exp = 8'h00;
  logic [2:0] m_vec = 3'd0;
  int         m_e = 0;

  initial forever begin
    @(posedge clk);
    if (rst) begin
      m_busy = 1'b0; m_done = 1'b0; m_tt = 8'h00; m_vec = 3'd0; m_e = 0;
    end else if (start && !m_busy) begin
      m_exp = expected_tt; m_tt = 8'h00; m_vec = 3'd0; m_e = 0;
      m_busy = 1'b1; m_done = 1'b0;
    end else if (m_busy) begin
      m_e++;
      if (m_e % (S + 1) == 0) m_tt[m_e / (S + 1) - 1] = fut[m_e / (S + 1) - 1];
      if (m_e == 8 * (S + 1)) begin
        m_busy = 1'b0; m_done = 1'b1; m_vec = 3'd7;
      end else begin
        m_vec = 3'(m_e / (S + 1));
      end
    end
  end

  function automatic int lowest_diff(input logic [7:0] a, input logic [7:0] b);
    for (int k = 0; k < 8; k++) if (a[k] != b[k]) return k;
    return 0;
  endfunction

  always @(negedge clk) begin
    chk("vec", vec, m_vec);
    chk("busy", busy, m_busy);
    chk("done", done, m_done);
    chk("tt", tt, m_tt);
    if (m_done) begin
      chk("pass", pass, m_tt == m_exp);
      chk("fail", fail, m_tt != m_exp);
      chk("first_bad", first_bad, lowest_diff(m_tt, m_exp));
      chk("ones", ones, $countones(m_tt));
    end else begin
      chk("pass_idle", pass, 0);
      chk("fail_idle", fail, 0);
    end
  end

  // n returns the edge count to done, or -2 if the scan was reset away.
  task automatic scan(input logic [7:0] exp, input int restart_at, input int reset_at,
                      input int xchg_at, output int n);
    @(negedge clk);
    expected_tt = exp;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    chk("acc_done", done, 0);
    chk("acc_vec", vec, 0);
    chk("acc_busy", busy, 1);
    n = -1;
    for (int i = 1; i <= 40; i++) begin
      @(posedge clk); #1;
      if (i == reset_at) begin
        rst = 1'b0;
        chk("rst_vec", vec, 0);
        chk("rst_busy", busy, 0);
        chk("rst_tt", tt, 0);
        chk("rst_done", done, 0);
        n = -2;
        break;
      end
      if (done) begin
        n = i;
        break;
      end
      if (i == reset_at - 1) rst = 1'b1;
      if (i == restart_at) start = 1'b1;
      if (i == restart_at + 1) start = 1'b0;
      if (i == xchg_at) expected_tt = 8'h00;
    end
    if (n != -2) chk("done_edge", n, 16);
    $display("scan exp=%h tt=%h pass=%0b first_bad=%0d ones=%0d edges=%0d",
             exp, tt, pass, first_bad, ones, n);
  endtask

  int n;

  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk("reset_vec", vec, 0);
    chk("reset_busy", busy, 0);
    chk("reset_done", done, 0);
    chk("reset_tt", tt, 0);
    chk("reset_first_bad", first_bad, 0);
    chk("reset_ones", ones, 0);
    chk("reset_pass", pass, 0);
    chk("reset_fail", fail, 0);
    @(negedge clk);
    rst = 1'b0;
    fut = 8'hEA;  // f = (x&y)|z

    scan(8'hEA, 0, 0, 0, n);
    chk("d1_tt", tt, 8'hEA); chk("d1_pass", pass, 1); chk("d1_fail", fail, 0);
    chk("d1_first_bad", first_bad, 0); chk("d1_ones", ones, 5);

    scan(8'hEB, 0, 0, 0, n);
    chk("d2_tt", tt, 8'hEA); chk("d2_pass", pass, 0); chk("d2_fail", fail, 1);
    chk("d2_first_bad", first_bad, 0);

    scan(8'h6A, 0, 0, 0, n);
    chk("d3_fail", fail, 1); chk("d3_first_bad", first_bad, 7);

    scan(8'hEA, 5, 0, 0, n);
    chk("d4_tt", tt, 8'hEA); chk("d4_pass", pass, 1);

    scan(8'hEA, 0, 0, 3, n);
    chk("d5_pass_latched", pass, 1);

    scan(8'hEA, 0, 7, 0, n);
    scan(8'hEA, 0, 0, 0, n);
    chk("d6_tt", tt, 8'hEA); chk("d6_pass", pass, 1);

    @(negedge clk);
    start0 = 1'b1;
    @(posedge clk); #1;
    start0 = 1'b0;
    n = -1;
    for (int i = 1; i <= 20; i++) begin
      @(posedge clk); #1;
      if (done0) begin
        n = i;
        break;
      end
    end
    chk("s0_done_edge", n, 8);
    chk("s0_tt", tt0, 8'hFF);
    chk("s0_ones", ones0, 8);
    chk("s0_pass", pass0, 1);
    $display("scan settle0 tt=%h ones=%0d edges=%0d", tt0, ones0, n);

    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      rst = ($urandom_range(0, 199) == 0);
      start = ($urandom_range(0, 7) == 0);
      expected_tt = 8'($urandom);
      if (!m_busy) fut = ($urandom_range(0, 1) == 1) ? expected_tt : 8'($urandom);
    end
    @(negedge clk);
    rst = 1'b0;
    start = 1'b0;
    repeat (2) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
